// File: rtl/conv_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : conv_seq_ctrl_if
//  Description : Handshake and memory-address bundle between the convolution
//                sequencer and its X/F memories, MAC datapath and Y consumer.
//  Revision    : 1.0  initial release
// ============================================================================
interface conv_seq_ctrl_if #(
    parameter int X_SIZE   = 8,
    parameter int F_SIZE   = 4,
    parameter int X_ADDR_W = (X_SIZE > 1) ? $clog2(X_SIZE) : 1,
    parameter int F_ADDR_W = (F_SIZE > 1) ? $clog2(F_SIZE) : 1,
    parameter int Y_IDX_W  = ((X_SIZE - F_SIZE) > 0) ? $clog2(X_SIZE - F_SIZE + 1) : 1
);
    logic                conv_start;
    logic                m_ready_y;
    logic [X_ADDR_W-1:0] xmem_raddr;
    logic [F_ADDR_W-1:0] fmem_raddr;
    logic                reset_accum;
    logic                en_accum;
    logic                m_valid_y;
    logic [Y_IDX_W-1:0]  y_idx;
    logic                conv_done;
    logic                busy;

    // Sequencer side
    modport master (
        input  conv_start, m_ready_y,
        output xmem_raddr, fmem_raddr, reset_accum, en_accum,
               m_valid_y, y_idx, conv_done, busy
    );

    // Memory / datapath / consumer side
    modport slave (
        output conv_start, m_ready_y,
        input  xmem_raddr, fmem_raddr, reset_accum, en_accum,
               m_valid_y, y_idx, conv_done, busy
    );
endinterface
`default_nettype wire

// File: rtl/conv_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : conv_seq_ctrl
//  Description : Sequencer for a valid-mode 1-D convolution. For each output
//                n it walks taps k=0..F_SIZE-1, drives X/F read addresses,
//                clears then enables the external MAC accumulator (one-cycle
//                memory latency), presents Y with a valid/ready handshake and
//                pulses conv_done after the last output.
//  Revision    : 1.0  initial release
// ============================================================================
module conv_seq_ctrl #(
    parameter int X_SIZE   = 8,
    parameter int F_SIZE   = 4,
    parameter int X_ADDR_W = (X_SIZE > 1) ? $clog2(X_SIZE) : 1,
    parameter int F_ADDR_W = (F_SIZE > 1) ? $clog2(F_SIZE) : 1
) (
    input  logic             clk,
    input  logic             reset,
    conv_seq_ctrl_if.master  bus
);
    localparam int c_N_MAX = X_SIZE - F_SIZE;
    localparam int c_N_W   = (c_N_MAX > 0) ? $clog2(c_N_MAX + 1) : 1;
    localparam int c_K_W   = $clog2(F_SIZE + 1);

    localparam logic [c_N_W-1:0] c_N_LAST = c_N_W'(c_N_MAX);
    localparam logic [c_K_W-1:0] c_K_LAST = c_K_W'(F_SIZE);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_OUT  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [c_N_W-1:0] r_n;
    logic [c_N_W-1:0] w_n_nxt;
    logic [c_K_W-1:0] r_k;
    logic [c_K_W-1:0] w_k_nxt;
    logic [c_K_W-1:0] w_k_clamp;

    // State and counters; reset aborts any convolution in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_n     <= '0;
            r_k     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_n     <= w_n_nxt;
            r_k     <= w_k_nxt;
        end
    end

    // Next-state and counter sequencing
    always_comb begin
        w_state_nxt = r_state;
        w_n_nxt     = r_n;
        w_k_nxt     = r_k;
        case (r_state)
            S_IDLE: begin
                if (bus.conv_start) begin
                    w_state_nxt = S_MAC;
                    w_n_nxt     = '0;
                    w_k_nxt     = '0;
                end
            end
            S_MAC: begin
                // k=F_SIZE is the extra cycle that absorbs the read latency
                if (r_k == c_K_LAST) begin
                    w_state_nxt = S_OUT;
                end else begin
                    w_k_nxt = r_k + c_K_W'(1);
                end
            end
            S_OUT: begin
                if (bus.m_ready_y) begin
                    if (r_n == c_N_LAST) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_MAC;
                        w_n_nxt     = r_n + c_N_W'(1);
                        w_k_nxt     = '0;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_n_nxt     = '0;
                w_k_nxt     = '0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_n_nxt     = '0;
                w_k_nxt     = '0;
            end
        endcase
    end

    // Past the last tap the addresses hold on the final tap; with n=k=0 they
    // read zero, which keeps reset and idle outputs at 0.
    assign w_k_clamp = (r_k == c_K_LAST) ? (c_K_LAST - c_K_W'(1)) : r_k;

    // All outputs decode from registered state and counters only
    assign bus.xmem_raddr  = X_ADDR_W'(r_n) + X_ADDR_W'(w_k_clamp);
    assign bus.fmem_raddr  = F_ADDR_W'(w_k_clamp);
    assign bus.reset_accum = (r_state == S_MAC) && (r_k == '0);
    assign bus.en_accum    = (r_state == S_MAC) && (r_k != '0);
    assign bus.m_valid_y   = (r_state == S_OUT);
    assign bus.conv_done   = (r_state == S_DONE);
    assign bus.busy        = (r_state != S_IDLE);
    assign bus.y_idx       = r_n;

endmodule
`default_nettype wire

// File: tb/tb_conv_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_conv_seq_ctrl
//  Description : Scoreboard bench for conv_seq_ctrl with X/F memory and MAC
//                accumulator models driven by the sequencer outputs.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_conv_seq_ctrl;
    localparam int X_SIZE = 8;
    localparam int F_SIZE = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    conv_seq_ctrl_if #(.X_SIZE(X_SIZE), .F_SIZE(F_SIZE)) bus ();

    conv_seq_ctrl #(.X_SIZE(X_SIZE), .F_SIZE(F_SIZE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Memory and accumulator models
    logic [7:0]  xmem [X_SIZE];
    logic [7:0]  fmem [F_SIZE];
    logic [7:0]  xq;
    logic [7:0]  fq;
    logic [15:0] acc;

    always @(posedge clk) begin
        xq <= xmem[bus.xmem_raddr];
        fq <= fmem[bus.fmem_raddr];
        if (bus.reset_accum)   acc <= 16'd0;
        else if (bus.en_accum) acc <= acc + 16'(xq * fq);
    end

    typedef struct { int idx; int y; } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    int n_total  = 0;
    int n_pass   = 0;
    int done_cnt = 0;

    bit         trace_on = 1'b0;
    logic [6:0] trace_q[$];
    logic [6:0] exp_tr[5] = '{7'b010_00_1_0, 7'b011_01_0_1, 7'b100_10_0_1,
                              7'b101_11_0_1, 7'b101_11_0_1};

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic fail(input string name);
        n_total++;
        $display("FAIL %s: got bound expired, expected DUT event", name);
    endtask

    function automatic longint outs();
        return longint'({bus.xmem_raddr, bus.fmem_raddr, bus.reset_accum, bus.en_accum,
                         bus.m_valid_y, bus.y_idx, bus.conv_done, bus.busy});
    endfunction

    task automatic push_seq(input int first_y, input int step);
        for (int i = 0; i <= X_SIZE - F_SIZE; i++) exp_q.push_back('{i, first_y + i * step});
    endtask

    // Monitor: Y handshakes against scoreboard, done pulses, address trace
    always @(negedge clk) begin
        if (bus.m_valid_y && bus.m_ready_y) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_y: got idx %0d value %0d, expected none", bus.y_idx, acc);
            end else begin
                mon_e = exp_q.pop_front();
                check("y_idx", longint'(bus.y_idx), longint'(mon_e.idx));
                check("y_value", longint'(acc), longint'(mon_e.y));
            end
        end
        if (bus.conv_done) done_cnt++;
        if (trace_on && bus.busy && !bus.m_valid_y && !bus.conv_done && bus.y_idx == 2)
            trace_q.push_back({bus.xmem_raddr, bus.fmem_raddr, bus.reset_accum, bus.en_accum});
    end

    task automatic run_conv(input int stall_idx, input int hold_y, input int abort_idx,
                            input bit noise, input bit timing);
        int c;
        int first_v;
        int done_c;
        bit stalled;
        bit aborted;
        bit check_adv;
        first_v = 0; done_c = 0; stalled = 0; aborted = 0; check_adv = 0;
        bus.m_ready_y  = 1'b1;
        bus.conv_start = 1'b1;
        @(posedge clk); #1;
        bus.conv_start = 1'b0;
        c = 1;
        while (c <= 200 && done_c == 0 && !aborted) begin
            if (noise) bus.conv_start = (c == 3 || c == 6);
            if (check_adv) begin
                check("stall_advance_idx", longint'(bus.y_idx), longint'(stall_idx + 1));
                check("stall_advance_valid", longint'(bus.m_valid_y), 0);
                check_adv = 0;
            end
            if (bus.m_valid_y && first_v == 0) first_v = c;
            if (bus.conv_done) begin
                done_c = c;
            end else if (abort_idx >= 0 && bus.busy && !bus.m_valid_y && bus.y_idx == abort_idx
                         && bus.fmem_raddr == 2 && bus.en_accum) begin
                #2 reset = 1'b0;
                #1 check("abort_outputs_zero", outs(), 0);
                exp_q.delete();
                aborted = 1;
            end else if (stall_idx >= 0 && !stalled && bus.m_valid_y && bus.y_idx == stall_idx) begin
                stalled = 1;
                bus.m_ready_y = 1'b0;
                repeat (3) begin
                    @(posedge clk); #1; c++;
                    check("stall_valid", longint'(bus.m_valid_y), 1);
                    check("stall_hold_y", longint'(acc), longint'(hold_y));
                    check("stall_idx", longint'(bus.y_idx), longint'(stall_idx));
                    check("stall_no_accum", longint'({bus.en_accum, bus.reset_accum}), 0);
                end
                bus.m_ready_y = 1'b1;
                check_adv = 1;
            end
            if (done_c == 0 && !aborted) begin
                @(posedge clk); #1; c++;
            end
        end
        if (done_c == 0 && !aborted) fail("run_timeout");
        if (timing) begin
            check("first_valid_cycle", longint'(first_v), longint'(F_SIZE + 2));
            check("done_cycle", longint'(done_c), longint'((X_SIZE - F_SIZE + 1) * (F_SIZE + 2) + 1));
        end
    endtask

    task automatic wait_done(input string name);
        int c;
        c = 0;
        do begin
            @(posedge clk); #1; c++;
        end while (!bus.conv_done && c < 100);
        if (!bus.conv_done) fail(name);
    endtask

    task automatic idle_checks(input int cycles);
        repeat (cycles) begin
            @(posedge clk); #1;
            check("idle_busy", longint'(bus.busy), 0);
            check("idle_valid", longint'(bus.m_valid_y), 0);
        end
    endtask

    initial begin
        bus.conv_start = 1'b0;
        bus.m_ready_y  = 1'b0;
        #1 reset = 1'b0;
        #1 check("reset_outputs", outs(), 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        // m_ready_y high in IDLE must not start anything
        bus.m_ready_y = 1'b1;
        idle_checks(4);

        // X=1..8, F=1s: Y=10,14,18,22,26; conv_start noise during MAC/OUT
        for (int i = 0; i < X_SIZE; i++) xmem[i] = 8'(i + 1);
        for (int i = 0; i < F_SIZE; i++) fmem[i] = 8'd1;
        push_seq(10, 4);
        trace_on = 1'b1;
        run_conv(-1, 0, -1, 1'b1, 1'b1);
        trace_on = 1'b0;
        check("trace_len", longint'(trace_q.size()), 5);
        for (int i = 0; i < 5 && i < trace_q.size(); i++)
            check("trace_n2", longint'(trace_q[i]), longint'(exp_tr[i]));
        repeat (2) @(posedge clk);
        #1;

        // Back-pressure: ready low for 3 cycles at y_idx=1 (Y=14 held)
        push_seq(10, 4);
        run_conv(1, 14, -1, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;

        // Reset at n=3, k=2 aborts; then a clean run from y_idx=0
        push_seq(10, 4);
        run_conv(-1, 0, 3, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        idle_checks(3);
        push_seq(10, 4);
        run_conv(-1, 0, -1, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #1;

        // conv_start held through DONE: one IDLE cycle, then a second run
        for (int i = 0; i < X_SIZE; i++) xmem[i] = 8'd2;
        for (int i = 0; i < F_SIZE; i++) fmem[i] = 8'd2;
        push_seq(16, 0);
        push_seq(16, 0);
        bus.conv_start = 1'b1;
        wait_done("rearm_first_done");
        @(posedge clk); #1;
        check("rearm_idle_busy", longint'(bus.busy), 0);
        check("rearm_idle_idx", longint'(bus.y_idx), 0);
        @(posedge clk); #1;
        check("rearm_mac_busy", longint'(bus.busy), 1);
        check("rearm_mac_reset_accum", longint'(bus.reset_accum), 1);
        check("rearm_mac_idx", longint'(bus.y_idx), 0);
        bus.conv_start = 1'b0;
        wait_done("rearm_second_done");
        repeat (3) @(posedge clk);
        #1;

        check("queue_empty", longint'(exp_q.size()), 0);
        check("done_pulses", longint'(done_cnt), 5);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
